// File: rtl/exposure_sequencer.sv
// exposure_sequencer: latches an exposure recipe (on_ms, off_ms, reps) on a
// fire request and drives the UV relay through reps timed ON periods
// separated by OFF gaps, reporting progress for the display path.
// Optional build macro: EXPOSURE_CLAMP_EN saturates latched on_ms, off_ms
// and reps to 9999 as a panel-independent safety limit.
module exposure_sequencer #(
    parameter int MS_DIV = 16000,
    parameter int TIME_W = 14,
    parameter int REP_W  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [TIME_W-1:0] on_ms,
    input  logic [TIME_W-1:0] off_ms,
    input  logic [REP_W-1:0]  reps,
    output logic              relay,
    output logic              busy,
    output logic [REP_W-1:0]  rep_count,
    output logic [TIME_W-1:0] remaining_ms,
    output logic              done,
    output logic              aborted
);
    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

    // MS_DIV=1 still needs a one-bit prescaler that simply wraps every cycle
    localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(MS_DIV - 1);

    function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] v);
`ifdef EXPOSURE_CLAMP_EN
        if (32'(v) > 32'd9999) return TIME_W'(32'd9999);
`endif
        return v;
    endfunction

    function automatic logic [REP_W-1:0] clamp_reps(input logic [REP_W-1:0] v);
`ifdef EXPOSURE_CLAMP_EN
        if (32'(v) > 32'd9999) return REP_W'(32'd9999);
`endif
        return v;
    endfunction

    state_t              state_q, state_d;
    logic                relay_q, relay_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;
    logic [REP_W-1:0]    rep_count_q, rep_count_d;
    logic [TIME_W-1:0]   remaining_q, remaining_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [TIME_W-1:0]   on_sh_q, on_sh_d;
    logic [TIME_W-1:0]   off_sh_q, off_sh_d;
    logic [REP_W-1:0]    reps_sh_q, reps_sh_d;

    logic [TIME_W-1:0]   on_in, off_in;
    logic [REP_W-1:0]    reps_in;
    logic [REP_W:0]      rep_next;
    logic                wrap, more_reps;

    // State and output registers; relay drops asynchronously with rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            relay_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            rep_count_q <= '0;
            remaining_q <= '0;
            presc_q     <= '0;
            on_sh_q     <= '0;
            off_sh_q    <= '0;
            reps_sh_q   <= '0;
        end else begin
            state_q     <= state_d;
            relay_q     <= relay_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            rep_count_q <= rep_count_d;
            remaining_q <= remaining_d;
            presc_q     <= presc_d;
            on_sh_q     <= on_sh_d;
            off_sh_q    <= off_sh_d;
            reps_sh_q   <= reps_sh_d;
        end
    end

    // Next-state, phase timing and progress counters
    always_comb begin
        state_d     = state_q;
        relay_d     = relay_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        rep_count_d = rep_count_q;
        remaining_d = remaining_q;
        presc_d     = presc_q;
        on_sh_d     = on_sh_q;
        off_sh_d    = off_sh_q;
        reps_sh_d   = reps_sh_q;

        on_in     = clamp_time(on_ms);
        off_in    = clamp_time(off_ms);
        reps_in   = clamp_reps(reps);
        wrap      = (presc_q == PRESC_MAX);
        rep_next  = {1'b0, rep_count_q} + 1'b1;
        more_reps = (rep_next < {1'b0, reps_sh_q});

        unique case (state_q)
            S_IDLE: begin
                relay_d = 1'b0;
                busy_d  = 1'b0;
                if (start && !abort) begin
                    on_sh_d     = on_in;
                    off_sh_d    = off_in;
                    reps_sh_d   = reps_in;
                    rep_count_d = '0;
                    presc_d     = '0;
                    if (reps_in == '0) begin
                        done_d      = 1'b1;
                        remaining_d = '0;
                    end else begin
                        // on_ms=0 still visits ON for one cycle with relay low
                        state_d     = S_ON;
                        busy_d      = 1'b1;
                        relay_d     = (on_in != '0);
                        remaining_d = on_in;
                    end
                end
            end
            S_ON: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    relay_d     = 1'b0;
                    busy_d      = 1'b0;
                    aborted_d   = 1'b1;
                    remaining_d = '0;
                    presc_d     = '0;
                end else if (remaining_q == '0 || (wrap && remaining_q == TIME_W'(1))) begin
                    rep_count_d = rep_next[REP_W-1:0];
                    presc_d     = '0;
                    if (!more_reps) begin
                        state_d     = S_IDLE;
                        relay_d     = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        remaining_d = '0;
                    end else if (off_sh_q != '0) begin
                        state_d     = S_OFF;
                        relay_d     = 1'b0;
                        remaining_d = off_sh_q;
                    end else begin
                        // back-to-back ON: relay_d stays high, no glitch
                        state_d     = S_ON;
                        relay_d     = (on_sh_q != '0);
                        remaining_d = on_sh_q;
                    end
                end else begin
                    presc_d = wrap ? '0 : presc_q + 1'b1;
                    if (wrap) remaining_d = remaining_q - 1'b1;
                end
            end
            S_OFF: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    relay_d     = 1'b0;
                    busy_d      = 1'b0;
                    aborted_d   = 1'b1;
                    remaining_d = '0;
                    presc_d     = '0;
                end else if (remaining_q == '0 || (wrap && remaining_q == TIME_W'(1))) begin
                    state_d     = S_ON;
                    presc_d     = '0;
                    relay_d     = (on_sh_q != '0);
                    remaining_d = on_sh_q;
                end else begin
                    presc_d = wrap ? '0 : presc_q + 1'b1;
                    if (wrap) remaining_d = remaining_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                relay_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign relay        = relay_q;
    assign busy         = busy_q;
    assign rep_count    = rep_count_q;
    assign remaining_ms = remaining_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
endmodule

// File: tb/tb_exposure_sequencer.sv
// Directed bench for exposure_sequencer (MS_DIV=4 main instance, MS_DIV=1
// instance for the long-exposure clamp case).
module tb_exposure_sequencer;
    localparam int TIME_W = 14;
    localparam int REP_W  = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0;
    logic [TIME_W-1:0] on_ms = '0, off_ms = '0;
    logic [REP_W-1:0]  reps = '0;
    logic relay, busy, done, aborted;
    logic [REP_W-1:0]  rep_count;
    logic [TIME_W-1:0] remaining_ms;

    logic start_c = 1'b0, abort_c = 1'b0;
    logic [TIME_W-1:0] on_c = '0, off_c = '0;
    logic [REP_W-1:0]  reps_c = '0;
    logic relay_c, busy_c, done_c, aborted_c;
    logic [REP_W-1:0]  rep_count_c;
    logic [TIME_W-1:0] remaining_c;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    exposure_sequencer #(.MS_DIV(4), .TIME_W(TIME_W), .REP_W(REP_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .on_ms(on_ms), .off_ms(off_ms), .reps(reps),
        .relay(relay), .busy(busy), .rep_count(rep_count),
        .remaining_ms(remaining_ms), .done(done), .aborted(aborted)
    );

    exposure_sequencer #(.MS_DIV(1), .TIME_W(TIME_W), .REP_W(REP_W)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .abort(abort_c),
        .on_ms(on_c), .off_ms(off_c), .reps(reps_c),
        .relay(relay_c), .busy(busy_c), .rep_count(rep_count_c),
        .remaining_ms(remaining_c), .done(done_c), .aborted(aborted_c)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Start pulse on one edge; returns at the negedge after that edge (k=0)
    task automatic pulse_start(input int on_v, input int off_v, input int reps_v);
        on_ms  = TIME_W'(on_v);
        off_ms = TIME_W'(off_v);
        reps   = REP_W'(reps_v);
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({relay, busy, done, aborted, rep_count, remaining_ms} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got relay=%0b busy=%0b done=%0b aborted=%0b rep=%0d rem=%0d, want all 0",
                     relay, busy, done, aborted, rep_count, remaining_ms);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({relay, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL reset_idle: got relay=%0b busy=%0b done=%0b, want 0 0 0", relay, busy, done);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic exp_relay;
        pulse_start(3, 2, 2);
        for (int k = 0; k <= 33; k++) begin
            exp_relay = (k <= 11) || (k >= 20 && k <= 31);
            checks++;
            if (relay !== exp_relay || done !== (k == 32)) begin
                fails++;
                $display("FAIL basic_k%0d: got relay=%0b done=%0b, want relay=%0b done=%0b",
                         k, relay, done, exp_relay, (k == 32));
            end
            if (k == 32) begin
                checks++;
                if (rep_count !== REP_W'(2) || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL basic_final: got rep=%0d busy=%0b, want rep=2 busy=0", rep_count, busy);
                end
            end
            step();
        end
        $display("test_basic done");
    endtask

    task automatic test_zero_reps();
        pulse_start(5, 5, 0);
        checks++;
        if (done !== 1'b1 || relay !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_reps_k0: got done=%0b relay=%0b busy=%0b, want 1 0 0", done, relay, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || relay !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_reps_k1: got done=%0b relay=%0b busy=%0b, want 0 0 0", done, relay, busy);
        end
        $display("test_zero_reps done");
    endtask

    task automatic test_back_to_back();
        int done_cnt = 0;
        pulse_start(2, 0, 3);
        for (int k = 0; k <= 27; k++) begin
            if (done) done_cnt++;
            checks++;
            if (relay !== (k <= 23)) begin
                fails++;
                $display("FAIL b2b_relay_k%0d: got %0b want %0b", k, relay, (k <= 23));
            end
            if (k == 7 || k == 8 || k == 16 || k == 24) begin
                checks++;
                if (rep_count !== REP_W'(k / 8)) begin
                    fails++;
                    $display("FAIL b2b_rep_k%0d: got %0d want %0d", k, rep_count, k / 8);
                end
            end
            step();
        end
        checks++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL b2b_done_count: got %0d want 1", done_cnt);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_abort();
        int done_seen = 0;
        abort = 1'b1;
        step();
        checks++;
        if (aborted !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: got aborted=%0b busy=%0b want 0 0", aborted, busy);
        end
        abort = 1'b0;
        pulse_start(100, 0, 1);
        for (int k = 0; k < 19; k++) step();
        checks++;
        if (relay !== 1'b1) begin
            fails++;
            $display("FAIL abort_pre: got relay=%0b want 1", relay);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (relay !== 1'b0 || aborted !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rep_count !== '0) begin
            fails++;
            $display("FAIL abort_hit: got relay=%0b aborted=%0b busy=%0b done=%0b rep=%0d want 0 1 0 0 0",
                     relay, aborted, busy, done, rep_count);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            if (done) done_seen++;
        end
        checks++;
        if (aborted !== 1'b0 || done_seen != 0 || relay !== 1'b0) begin
            fails++;
            $display("FAIL abort_after: got aborted=%0b done_seen=%0d relay=%0b want 0 0 0", aborted, done_seen, relay);
        end
        // simultaneous start and abort in IDLE: no run
        on_ms = 3; off_ms = 0; reps = 1; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (relay !== 1'b0 || busy !== 1'b0 || aborted !== 1'b0) begin
            fails++;
            $display("FAIL abort_vs_start: got relay=%0b busy=%0b aborted=%0b want 0 0 0", relay, busy, aborted);
        end
        $display("test_abort done");
    endtask

    task automatic test_reset_mid_run();
        pulse_start(1, 5, 3);
        for (int k = 0; k < 5; k++) step();
        checks++;
        if (busy !== 1'b1 || relay !== 1'b0 || rep_count !== REP_W'(1)) begin
            fails++;
            $display("FAIL rst_pre_off: got busy=%0b relay=%0b rep=%0d want 1 0 1", busy, relay, rep_count);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (relay !== 1'b0 || busy !== 1'b0 || rep_count !== '0) begin
            fails++;
            $display("FAIL rst_mid_off: got relay=%0b busy=%0b rep=%0d want 0 0 0", relay, busy, rep_count);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        pulse_start(4, 0, 1);
        step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (relay !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_on: got relay=%0b busy=%0b want 0 0", relay, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        pulse_start(1, 1, 1);
        for (int k = 0; k <= 4; k++) begin
            checks++;
            if (relay !== (k <= 3) || done !== (k == 4)) begin
                fails++;
                $display("FAIL rst_rerun_k%0d: got relay=%0b done=%0b want %0b %0b", k, relay, done, (k <= 3), (k == 4));
            end
            step();
        end
        $display("test_reset_mid_run done");
    endtask

    task automatic test_start_while_busy();
        pulse_start(2, 1, 2);
        for (int k = 0; k <= 21; k++) begin
            checks++;
            if (relay !== (k <= 7 || (k >= 12 && k <= 19)) || done !== (k == 20)) begin
                fails++;
                $display("FAIL busy_start_k%0d: got relay=%0b done=%0b want %0b %0b",
                         k, relay, done, (k <= 7 || (k >= 12 && k <= 19)), (k == 20));
            end
            if (k == 0 || k == 4 || k == 8) begin
                checks++;
                if (remaining_ms !== TIME_W'((k == 0) ? 2 : 1)) begin
                    fails++;
                    $display("FAIL busy_rem_k%0d: got %0d want %0d", k, remaining_ms, (k == 0) ? 2 : 1);
                end
            end
            if (k == 3) begin start = 1'b1; on_ms = 5; off_ms = 7; reps = 9; end
            if (k == 4) start = 1'b0;
            step();
        end
        $display("test_start_while_busy done");
    endtask

    task automatic test_retrigger();
        on_ms = 1; off_ms = 0; reps = 1; start = 1'b1;
        step();
        for (int k = 0; k <= 9; k++) begin
            checks++;
            if (relay !== (k <= 3 || (k >= 5 && k <= 8)) || done !== (k == 4 || k == 9)) begin
                fails++;
                $display("FAIL retrig_k%0d: got relay=%0b done=%0b want %0b %0b",
                         k, relay, done, (k <= 3 || (k >= 5 && k <= 8)), (k == 4 || k == 9));
            end
            if (k == 5) start = 1'b0;
            step();
        end
        $display("test_retrigger done");
    endtask

    task automatic test_clamp();
        int cnt = 0;
        int exp_cnt;
`ifdef EXPOSURE_CLAMP_EN
        exp_cnt = 9999;
`else
        exp_cnt = 16000;
`endif
        on_c = 16000; off_c = 0; reps_c = 1; start_c = 1'b1;
        step();
        start_c = 1'b0;
        while (relay_c === 1'b1 && cnt < 20000) begin
            cnt++;
            step();
        end
        checks++;
        if (cnt != exp_cnt || done_c !== 1'b1) begin
            fails++;
            $display("FAIL clamp_len: got %0d cycles done=%0b want %0d cycles done=1", cnt, done_c, exp_cnt);
        end
        $display("test_clamp done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_reps();
        test_back_to_back();
        test_abort();
        test_reset_mid_run();
        test_start_while_busy();
        test_retrigger();
        test_clamp();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
